// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// Each cycle at most one Avalon-MM command is accepted. The command is
// registered onto the RAM port, and read data returns to its issuer a
// fixed three cycles after acceptance. Writes are posted.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   m0_* / m1_*               Avalon-MM slave ports (address, byteenable,
//                             read, write, writedata, waitrequest,
//                             readdata, readdatavalid)
//   mem_*                     RAM port (address, byteenable, chipselect,
//                             write, writedata, clken, readdata)
module onchip_mem_arbiter #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BE_W      = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    PRI_M0 = 1'b0,
    PRI_M1 = 1'b1
  } pri_e;

  pri_e             pri_q, pri_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic req0, req1;
  logic grant0, grant1;
  logic accept;
  logic sel_write;
  logic rd_accept;

  // Read-return tag pipeline: stage 0 = command on RAM port, stage 1 = RAM
  // data valid; the readdatavalid registers form the final stage.
  logic [1:0] rd_vld_q;
  logic [1:0] rd_id_q;

  // Same-cycle grant and waitrequest
  always_comb begin
    req0           = m0_read | m0_write;
    req1           = m1_read | m1_write;
    grant0         = reset_n & req0 & (~req1 | (pri_q == PRI_M0));
    grant1         = reset_n & req1 & (~req0 | (pri_q == PRI_M1));
    accept         = grant0 | grant1;
    // Simultaneous read+write is treated as a write
    sel_write      = grant1 ? m1_write : m0_write;
    rd_accept      = accept & ~sel_write;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (reset_n) begin
      // An idle master sees waitrequest low only while it holds priority
      m0_waitrequest = req0 ? ~grant0 : (pri_q != PRI_M0);
      m1_waitrequest = req1 ? ~grant1 : (pri_q != PRI_M1);
    end
  end

  // Priority pointer / burst counter next state
  always_comb begin
    pri_d   = pri_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (accept) begin
      if ((grant0 && pri_q == PRI_M0) || (grant1 && pri_q == PRI_M1)) begin
        if (grant0 ? req1 : req0) begin
          if (cnt_inc == CNT_W'(MAX_BURST)) begin
            pri_d = (pri_q == PRI_M0) ? PRI_M1 : PRI_M0;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end else begin
        pri_d = grant0 ? PRI_M0 : PRI_M1;
        cnt_d = '0;
      end
    end
  end

  // Priority state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pri_q <= PRI_M0;
      cnt_q <= '0;
    end else begin
      pri_q <= pri_d;
      cnt_q <= cnt_d;
    end
  end

  // Command stage onto the RAM port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_clken      <= 1'b0;
    end else begin
      mem_clken      <= 1'b1;
      mem_chipselect <= accept;
      mem_write      <= accept & sel_write;
      if (accept) begin
        mem_address    <= grant1 ? m1_address    : m0_address;
        mem_byteenable <= grant1 ? m1_byteenable : m0_byteenable;
        mem_writedata  <= grant1 ? m1_writedata  : m0_writedata;
      end
    end
  end

  // Read tag pipeline and data return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q         <= '0;
      rd_id_q          <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
    end else begin
      rd_vld_q         <= {rd_vld_q[0], rd_accept};
      rd_id_q          <= {rd_id_q[0], grant1};
      m0_readdatavalid <= rd_vld_q[1] & ~rd_id_q[1];
      m1_readdatavalid <= rd_vld_q[1] &  rd_id_q[1];
      if (rd_vld_q[1] && !rd_id_q[1]) begin
        m0_readdata <= mem_readdata;
      end
      if (rd_vld_q[1] && rd_id_q[1]) begin
        m1_readdata <= mem_readdata;
      end
    end
  end

  a_m0_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(m0_read && m0_write));
  a_m1_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(m1_read && m1_write));

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed self-checking bench for onchip_mem_arbiter (MAX_BURST = 2) with a
// behavioural 4096x32 RAM whose word a initially holds 32'h1000_0000 + a.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(
    .ADDR_W(12), .DATA_W(32), .BE_W(4), .MAX_BURST(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // Behavioural RAM: registered read, byte-lane writes
  logic [31:0] ram [0:4095];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 32'h1000_0000 + 32'(i);
      ram_loaded <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } cmd_t;

  typedef struct {
    cmd_t        c0;
    cmd_t        c1;
    logic        e_w0;
    logic        e_w1;
    logic        e_v0;
    logic [31:0] e_d0;
    logic        e_v1;
    logic [31:0] e_d1;
  } vec_t;

  function automatic cmd_t idle_c();
    cmd_t c;
    c.rd = 1'b0; c.wr = 1'b0; c.addr = 12'h0; c.be = 4'h0; c.wd = 32'h0;
    return c;
  endfunction

  function automatic cmd_t rd_c(input logic [11:0] a);
    cmd_t c;
    c = idle_c();
    c.rd = 1'b1; c.addr = a; c.be = 4'hF;
    return c;
  endfunction

  function automatic cmd_t wr_c(input logic [11:0] a, input logic [3:0] be,
                                input logic [31:0] d);
    cmd_t c;
    c.rd = 1'b0; c.wr = 1'b1; c.addr = a; c.be = be; c.wd = d;
    return c;
  endfunction

  function automatic vec_t mk(input cmd_t c0, input cmd_t c1,
                              input logic w0, input logic w1,
                              input logic v0, input logic [31:0] d0,
                              input logic v1, input logic [31:0] d1);
    vec_t v;
    v.c0 = c0; v.c1 = c1; v.e_w0 = w0; v.e_w1 = w1;
    v.e_v0 = v0; v.e_d0 = d0; v.e_v1 = v1; v.e_d1 = d1;
    return v;
  endfunction

  task automatic apply(input cmd_t c0, input cmd_t c1);
    m0_read = c0.rd; m0_write = c0.wr; m0_address = c0.addr;
    m0_byteenable = c0.be; m0_writedata = c0.wd;
    m1_read = c1.rd; m1_write = c1.wr; m1_address = c1.addr;
    m1_byteenable = c1.be; m1_writedata = c1.wd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam int NVEC = 21;
  vec_t        tbl [NVEC];
  logic [31:0] last0, last1;
  logic        prev_grant;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Vectors: m0 write/read, partial write, then two-master contention
    tbl[0]  = mk(wr_c(12'h010, 4'hF, 32'hDEADBEEF), idle_c(), 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(rd_c(12'h010), idle_c(), 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(idle_c(), idle_c(), 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(idle_c(), idle_c(), 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(idle_c(), idle_c(), 0, 1, 1, 32'hDEADBEEF, 0, 0);
    tbl[5]  = mk(wr_c(12'h020, 4'hF, 32'h11223344), idle_c(), 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(wr_c(12'h020, 4'b0101, 32'hAABBCCDD), idle_c(), 0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(rd_c(12'h020), idle_c(), 0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(idle_c(), idle_c(), 0, 1, 0, 0, 0, 0);
    tbl[9]  = mk(idle_c(), idle_c(), 0, 1, 0, 0, 0, 0);
    tbl[10] = mk(idle_c(), idle_c(), 0, 1, 1, 32'h11BB33DD, 0, 0);
    tbl[11] = mk(rd_c(12'h100), rd_c(12'h200), 0, 1, 0, 0, 0, 0);
    tbl[12] = mk(rd_c(12'h101), rd_c(12'h200), 0, 1, 0, 0, 0, 0);
    tbl[13] = mk(rd_c(12'h102), rd_c(12'h200), 1, 0, 0, 0, 0, 0);
    tbl[14] = mk(rd_c(12'h102), rd_c(12'h201), 1, 0, 1, 32'h1000_0100, 0, 0);
    tbl[15] = mk(rd_c(12'h102), rd_c(12'h202), 0, 1, 1, 32'h1000_0101, 0, 0);
    tbl[16] = mk(rd_c(12'h103), rd_c(12'h202), 0, 1, 0, 0, 1, 32'h1000_0200);
    tbl[17] = mk(idle_c(), idle_c(), 1, 0, 0, 0, 1, 32'h1000_0201);
    tbl[18] = mk(idle_c(), idle_c(), 1, 0, 1, 32'h1000_0102, 0, 0);
    tbl[19] = mk(idle_c(), idle_c(), 1, 0, 1, 32'h1000_0103, 0, 0);
    tbl[20] = mk(idle_c(), idle_c(), 1, 0, 0, 0, 0, 0);

    // Reset held three cycles with m0 requesting
    reset_n = 1'b0;
    apply(rd_c(12'h000), idle_c());
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst m0_waitrequest", 32'(m0_waitrequest), 32'd1);
      chk("rst mem_chipselect", 32'(mem_chipselect), 32'd0);
      chk("rst rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
    end
    chk("rst mem_clken", 32'(mem_clken), 32'd0);
    chk("rst m0_readdata", m0_readdata, 32'h0);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("release m0_waitrequest", 32'(m0_waitrequest), 32'd0);
    chk("release m1_waitrequest idle", 32'(m1_waitrequest), 32'd1);
    next_cycle();
    apply(idle_c(), idle_c());
    @(negedge clk);
    chk("release mem_chipselect", 32'(mem_chipselect), 32'd1);
    chk("release mem_clken", 32'(mem_clken), 32'd1);
    chk("release mem_write", 32'(mem_write), 32'd0);
    chk("release mem_address", 32'(mem_address), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("release rdv early", 32'(m0_readdatavalid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("release rdv", 32'(m0_readdatavalid), 32'd1);
    chk("release rdata", m0_readdata, 32'h1000_0000);
    next_cycle();

    // Table-driven vectors
    last0 = 32'h1000_0000;
    last1 = 32'h0;
    prev_grant = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i].c0, tbl[i].c1);
      @(negedge clk);
      if (tbl[i].e_v0) last0 = tbl[i].e_d0;
      if (tbl[i].e_v1) last1 = tbl[i].e_d1;
      chk($sformatf("row%0d m0_waitrequest", i), 32'(m0_waitrequest), 32'(tbl[i].e_w0));
      chk($sformatf("row%0d m1_waitrequest", i), 32'(m1_waitrequest), 32'(tbl[i].e_w1));
      chk($sformatf("row%0d m0_readdatavalid", i), 32'(m0_readdatavalid), 32'(tbl[i].e_v0));
      chk($sformatf("row%0d m1_readdatavalid", i), 32'(m1_readdatavalid), 32'(tbl[i].e_v1));
      chk($sformatf("row%0d m0_readdata", i), m0_readdata, last0);
      chk($sformatf("row%0d m1_readdata", i), m1_readdata, last1);
      chk($sformatf("row%0d mem_chipselect", i), 32'(mem_chipselect), 32'(prev_grant));
      prev_grant = ((tbl[i].c0.rd | tbl[i].c0.wr) & ~tbl[i].e_w0) |
                   ((tbl[i].c1.rd | tbl[i].c1.wr) & ~tbl[i].e_w1);
      next_cycle();
    end

    // Back-to-back: m1 reads 0x000..0x007 with m0 idle
    for (int c = 0; c < 11; c++) begin
      if (c < 8) apply(idle_c(), rd_c(12'(c)));
      else       apply(idle_c(), idle_c());
      @(negedge clk);
      if (c < 8) chk($sformatf("b2b%0d m1_waitrequest", c), 32'(m1_waitrequest), 32'd0);
      chk($sformatf("b2b%0d m1_readdatavalid", c), 32'(m1_readdatavalid), 32'(c >= 3));
      chk($sformatf("b2b%0d m0_readdatavalid", c), 32'(m0_readdatavalid), 32'd0);
      if (c >= 3)
        chk($sformatf("b2b%0d m1_readdata", c), m1_readdata, 32'h1000_0000 + 32'(c - 3));
      next_cycle();
    end

    // Mid-flight reset: two m0 reads (second one contended by m1), then reset
    apply(rd_c(12'h005), idle_c());
    @(negedge clk);
    chk("mid rd0 m0_waitrequest", 32'(m0_waitrequest), 32'd0);
    next_cycle();
    apply(rd_c(12'h006), rd_c(12'h040));
    @(negedge clk);
    chk("mid rd1 m0_waitrequest", 32'(m0_waitrequest), 32'd0);
    chk("mid rd1 m1_waitrequest", 32'(m1_waitrequest), 32'd1);
    next_cycle();
    apply(idle_c(), idle_c());
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid rst m0_waitrequest", 32'(m0_waitrequest), 32'd1);
    chk("mid rst mem_chipselect", 32'(mem_chipselect), 32'd0);
    chk("mid rst m0_readdatavalid", 32'(m0_readdatavalid), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c >= 4) apply(rd_c(12'h030), rd_c(12'h031));
      @(negedge clk);
      chk($sformatf("post%0d rdv", c), 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
      if (c == 0) begin
        chk("post m0_readdata", m0_readdata, 32'h0);
        chk("post idle m0_waitrequest", 32'(m0_waitrequest), 32'd0);
        chk("post idle m1_waitrequest", 32'(m1_waitrequest), 32'd1);
      end
      // Pointer M0 with cleared counter: grant order M0, M0, M1
      if (c >= 4) begin
        chk($sformatf("post%0d m0_waitrequest", c), 32'(m0_waitrequest), 32'(c == 6));
        chk($sformatf("post%0d m1_waitrequest", c), 32'(m1_waitrequest), 32'(c != 6));
      end
      next_cycle();
    end
    apply(idle_c(), idle_c());
    repeat (5) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
Two-master arbiter that shares the single-port 4096x32 on-chip RAM between two Avalon-MM requesters, for example the CPU data master and a DMA/timer-capture master.
- Grants at most one command per cycle, using round-robin with a bounded burst allowance.
- Registers the command onto the RAM port.
- Returns read data to the issuing master with fixed latency.
- Writes are posted and produce no response.

Parameters:
ADDR_W, 12, word address width (RAM depth 2**ADDR_W)
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
MAX_BURST, 4, max consecutive grants to one master while the other requests (1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  BE_W  master 0 byte lanes
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  low = m0 command accepted this cycle
m0_readdata  out  DATA_W  read data to m0
m0_readdatavalid  out  1  m0_readdata valid (one cycle per read)
m1_*  same eight ports as m0_*, for master 1
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  BE_W  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken
mem_readdata  in  DATA_W  from RAM readdata (valid one cycle after address is latched)

Behaviour:
- Single clock clk. reset_n is asynchronous assert, synchronous deassert (via the external reset synchroniser), active-low.
- Reset values:
  - mem_address, mem_byteenable, mem_writedata, m0/m1_readdata = 0
  - mem_chipselect, mem_write, m0/m1_readdatavalid = 0
  - mem_clken = 0 in reset, 1 otherwise
  - m0/m1_waitrequest = 1 while reset_n low
  - priority pointer = M0; burst counter = 0
- Request: reqN = mN_read | mN_write. mN_read & mN_write together is illegal: treat as write, and flag with a simulation assertion.
- Grant (combinational, same cycle):
  - Only one master requesting: that master is granted.
  - Both requesting: the master selected by the priority pointer is granted.
  - mN_waitrequest = ~(grantN). When the master is idle, waitrequest is held low only if that master holds priority; otherwise it is 1.
- Priority pointer / burst counter, updated on each accepted command:
  - Granted master == pointer and the other master is requesting: counter+1. When counter+1 == MAX_BURST, the pointer flips to the other master and the counter clears.
  - Other master not requesting: counter clears and the pointer stays on the granted master.
  - Grant to the non-pointer master (pointer master idle): the pointer moves to the granted master and the counter clears.
  - MAX_BURST=1 gives strict alternation under contention.
- Command stage, registered at the accepting edge:
  - mem_address, mem_byteenable, mem_writedata take the granted master's values.
  - mem_chipselect = 1; mem_write = granted write.
  - No grant: chipselect = 0 and write = 0; address and data hold.
- Throughput: one command per cycle, back-to-back, with no bubbles.
- Read latency:
  - Read accepted in cycle t: command on mem_* in t+1, RAM latches address at the end of t+1, mem_readdata valid in t+2.
  - The arbiter registers mem_readdata at the end of t+2 into the owner's mN_readdata; mN_readdatavalid is high for exactly cycle t+3.
  - Owner tag is carried in a 3-stage valid/id shift pipeline. Reads from both masters interleave in issue order.
- Readdata ownership: the non-owner's readdata holds its previous value.
- Write handling: a write followed immediately by a read of the same address returns the new data. The RAM processes commands in order, one per cycle.
- Reset mid-operation: all pipeline valids clear immediately. Outstanding reads are discarded and no readdatavalid is produced after reset_n rises; masters must reissue.
- Address and width handling: no address translation, no wrap logic; ADDR_W bits pass straight through.

Test Plan:
- Reset: hold reset_n low 3 cycles with m0_read=1 -> m0_waitrequest=1, mem_chipselect=0, all readdatavalid=0. Release -> m0 accepted on the first cycle.
- Write then read, m0 only: write 0xDEADBEEF to 0x010, be=4'hF, then read 0x010 -> m0_readdatavalid exactly 3 cycles after read accept, m0_readdata=0xDEADBEEF, m1_readdatavalid stays 0.
- Partial write: write 0x11223344 to 0x020 be=F, then 0xAABBCCDD be=4'b0101, then read -> 0x11BB33DD.
- Contention, MAX_BURST=2, both masters reading continuously from cycle 0 -> grant order M0,M0,M1,M1,M0,M0. Each readdatavalid returns on the correct master with matching data, one per cycle.
- Back-to-back: m1 issues 8 reads to 0x000..0x007 with m0 idle -> 8 consecutive accepts, 8 consecutive m1_readdatavalid cycles with data in address order.
- Mid-flight reset: m0 issues 2 reads, reset_n pulses low in the cycle after the second accept -> no m0_readdatavalid ever asserted, pointer=M0, counter=0 afterwards.
